// File: rtl/tlul_host_adapter.sv
// tlul_host_adapter: bridges a req/gnt/rvalid host port onto TL-UL, tracking in-flight
// requests in order and checking each response's source and opcode against the request.
package tlul_pkg;
  localparam int TL_AIW = 8;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [31:0]       a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    logic [15:0]       a_user;
    logic              d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [31:0]       d_data;
    logic [15:0]       d_user;
    logic              d_error;
    logic              a_ready;
  } tlul_d2h_t;
endpackage

module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int Outstanding = 2,
  parameter int SourceW     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        spurious_o,
  output tlul_h2d_t   tl_o,
  input  tlul_d2h_t   tl_i
);
  localparam int PtrW = Outstanding > 1 ? $clog2(Outstanding) : 1;
  localparam int CntW = $clog2(Outstanding + 1);
  localparam logic [PtrW-1:0]    PtrMax  = PtrW'(Outstanding - 1);
  localparam logic [SourceW-1:0] SrcMax  = SourceW'(Outstanding - 1);
  localparam logic [CntW-1:0]    CntFull = CntW'(Outstanding);

  logic [SourceW-1:0] src_mem_q [Outstanding];
  logic [SourceW-1:0] src_mem_d [Outstanding];
  logic [Outstanding-1:0] we_mem_q, we_mem_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SourceW-1:0] src_cnt_q, src_cnt_d;
  logic rvalid_q, rvalid_d, err_q, err_d, spurious_q, spurious_d;
  logic [31:0] rdata_q, rdata_d;
  logic full, empty, a_valid, a_fire, pop, head_we, resp_err;
  logic [SourceW-1:0] head_src;
  logic unused_tl;

  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, addr_i[1:0]};

  always_comb begin
    full = cnt_q == CntFull;
    empty = cnt_q == '0;
    // full is the registered occupancy, so a same-cycle pop never opens a slot early
    a_valid = req_i & ~full & rst_ni;
    a_fire = a_valid & tl_i.a_ready;
    gnt_o = a_fire;
    tl_o = '0;
    tl_o.a_valid = a_valid;
    tl_o.a_opcode = we_i ? (be_i == 4'hF ? PutFullData : PutPartialData) : Get;
    tl_o.a_size = 2'd2;
    tl_o.a_source = TL_AIW'(src_cnt_q);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask = we_i ? be_i : 4'hF;
    tl_o.a_data = we_i ? wdata_i : 32'h0;
    tl_o.d_ready = 1'b1;
    pop = tl_i.d_valid & ~empty;
    head_src = src_mem_q[rd_ptr_q];
    head_we = we_mem_q[rd_ptr_q];
    resp_err = tl_i.d_error | (tl_i.d_source != TL_AIW'(head_src)) |
               (head_we ? tl_i.d_opcode != AccessAck : tl_i.d_opcode != AccessAckData);
    src_mem_d = src_mem_q;
    we_mem_d = we_mem_q;
    if (a_fire) begin
      src_mem_d[wr_ptr_q] = src_cnt_q;
      we_mem_d[wr_ptr_q] = we_i;
    end
    wr_ptr_d = a_fire ? (wr_ptr_q == PtrMax ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == PtrMax ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    cnt_d = cnt_q + CntW'(a_fire) - CntW'(pop);
    src_cnt_d = a_fire ? (src_cnt_q == SrcMax ? '0 : src_cnt_q + 1'b1) : src_cnt_q;
    rvalid_d = pop;
    err_d = pop & resp_err;
    rdata_d = (pop & ~resp_err & ~head_we) ? tl_i.d_data : 32'h0;
    spurious_d = tl_i.d_valid & empty;
  end

  always_ff @(posedge clk_i) begin
    src_mem_q <= src_mem_d;
    we_mem_q <= we_mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      src_cnt_q <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      src_cnt_q <= src_cnt_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      spurious_q <= spurious_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o = err_q;
  assign rdata_o = rdata_q;
  assign spurious_o = spurious_q;
endmodule

// File: tb/tb_tlul_host_adapter.sv
// tb_tlul_host_adapter: directed and randomized checks of the TL-UL host adapter against
// a queue-based model of in-flight requests and an echoing 1-cycle device.
module tb_tlul_host_adapter;
  import tlul_pkg::*;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst_n = 0, req = 0, we = 0, a_rdy = 1;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] be = 4'hF;
  logic gnt, rvalid, err, spur;
  logic [31:0] rdata;
  tlul_h2d_t tl_o;
  tlul_d2h_t tl_i = '0;

  int checks = 0, errors = 0, cyc = 0, dut_gnts = 0;
  typedef struct {logic [1:0] src; logic we;} ent_t;
  typedef struct {logic [7:0] src; logic we; logic [31:0] addr;} dev_t;
  ent_t mq[$];
  dev_t dq[$];
  int m_src = 0;
  logic e_rv = 0, e_err = 0, e_sp = 0;
  logic [31:0] e_rd = 0;
  logic [7:0] last_src = 0;
  bit dev_on = 0, force_dv = 0, inj_err = 0, inj_src = 0, inj_op = 0, last_gnt = 0;

  tlul_host_adapter #(.Outstanding(2), .SourceW(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .spurious_o(spur), .tl_o(tl_o), .tl_i(tl_i)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive device side, check A channel, advance the model, check registered outputs.
  task automatic cycle();
    ent_t h;
    dev_t d;
    logic exp_av, exp_gnt, rerr;
    tl_i = '0;
    tl_i.a_ready = a_rdy;
    if (dev_on && dq.size() > 0) begin
      d = dq.pop_front();
      tl_i.d_valid = 1;
      tl_i.d_source = d.src ^ {7'd0, inj_src};
      tl_i.d_opcode = (d.we ^ inj_op) ? 3'd0 : 3'd1;
      tl_i.d_data = d.we ? 32'hBAD0_0000 : d.addr;
      tl_i.d_error = inj_err;
    end else if (force_dv) begin
      tl_i.d_valid = 1;
      tl_i.d_source = 8'($urandom_range(0, 3));
      tl_i.d_opcode = 3'd1;
      tl_i.d_data = $urandom;
    end
    #1;
    exp_av = req && rst_n && mq.size() < 2;
    exp_gnt = exp_av && a_rdy;
    dut_gnts += int'(gnt === 1'b1);
    check("a_valid", tl_o.a_valid, exp_av);
    check("gnt", gnt, exp_gnt);
    check("d_ready", tl_o.d_ready, 1);
    if (exp_av) begin
      check("a_opcode", tl_o.a_opcode, !we ? 4 : (be == 4'hF ? 0 : 1));
      check("a_mask", tl_o.a_mask, we ? be : 4'hF);
      check("a_data", tl_o.a_data, we ? wdata : 0);
      check("a_address", tl_o.a_address, addr & 32'hFFFF_FFFC);
      check("a_source", tl_o.a_source, m_src);
      check("a_size", tl_o.a_size, 2);
      last_src = tl_o.a_source;
    end
    e_rv = 0; e_err = 0; e_rd = 0; e_sp = 0;
    if (!rst_n) begin
      mq.delete();
      m_src = 0;
    end else begin
      if (tl_i.d_valid && mq.size() > 0) begin
        h = mq.pop_front();
        rerr = tl_i.d_error || tl_i.d_source != {6'd0, h.src} ||
               tl_i.d_opcode != (h.we ? 3'd0 : 3'd1);
        e_rv = 1;
        e_err = rerr;
        e_rd = (!h.we && !rerr) ? tl_i.d_data : 0;
      end else e_sp = tl_i.d_valid;
      if (exp_gnt) begin
        mq.push_back('{2'(m_src), we});
        m_src = (m_src + 1) % 2;
      end
    end
    if (exp_gnt) dq.push_back('{tl_o.a_source, we, addr});
    last_gnt = exp_gnt;
    cyc++;
    @(posedge clk);
    #1;
    check("rvalid", rvalid, e_rv);
    check("err", err, e_err);
    check("rdata", rdata, e_rd);
    check("spurious", spur, e_sp);
  endtask

  task automatic idle(int n);
    req = 0;
    repeat (n) cycle();
  endtask

  task automatic issue(logic w, logic [31:0] a, logic [3:0] b, logic [31:0] wd);
    req = 1; we = w; addr = a; be = b; wdata = wd;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_gnt) break;
    end
    check("issue_timeout", last_gnt, 1);
    req = 0;
  endtask

  int c0, g0;
  initial begin
    @(posedge clk);
    #1;
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
    check("rst_rvalid", rvalid, 0);
    check("rst_spur", spur, 0);
    dev_on = 1;
    c0 = cyc; g0 = dut_gnts;
    for (int i = 0; i < 4; i++) issue(0, 32'(i * 4), 4'hF, 0);
    check("b2b_cycles", cyc - c0, 4);
    check("b2b_gnts", dut_gnts - g0, 4);
    idle(3);
    issue(1, 32'h100, 4'hF, 32'hDEADBEEF);
    issue(1, 32'h104, 4'h3, 32'hDEADBEEF);
    idle(3);
    dev_on = 0;
    issue(0, 32'h10, 4'hF, 0);
    issue(0, 32'h14, 4'hF, 0);
    req = 1; we = 0; addr = 32'h18;
    g0 = dut_gnts;
    cycle();
    cycle();
    check("stall_hold", dut_gnts - g0, 0);
    dev_on = 1;
    cycle();
    check("stall_first_dfire", dut_gnts - g0, 0);
    cycle();
    check("stall_release", dut_gnts - g0, 1);
    idle(3);
    inj_err = 1;
    issue(0, 32'h20, 4'hF, 0);
    idle(1);
    check("derr_err", err, 1);
    check("derr_rdata", rdata, 0);
    inj_err = 0;
    inj_src = 1;
    issue(0, 32'h24, 4'hF, 0);
    idle(1);
    check("src_err", err, 1);
    inj_src = 0;
    inj_op = 1;
    issue(0, 32'h28, 4'hF, 0);
    idle(1);
    check("op_err", err, 1);
    inj_op = 0;
    idle(2);
    dev_on = 0;
    force_dv = 1;
    cycle();
    force_dv = 0;
    check("spur_pulse", spur, 1);
    check("spur_rvalid", rvalid, 0);
    idle(1);
    check("spur_once", spur, 0);
    issue(0, 32'h40, 4'hF, 0);
    issue(0, 32'h44, 4'hF, 0);
    req = 1; addr = 32'h48;
    rst_n = 0;
    cycle();
    rst_n = 1;
    req = 0;
    check("rst_mid_rvalid", rvalid, 0);
    dev_on = 1;
    cycle();
    check("late1_spur", spur, 1);
    check("late1_rvalid", rvalid, 0);
    cycle();
    check("late2_spur", spur, 1);
    issue(0, 32'h50, 4'hF, 0);
    check("post_rst_src", last_src, 0);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      if (!(req && !last_gnt)) begin
        req = ($urandom % 3) != 0;
        we = 1'($urandom);
        addr = $urandom;
        be = 4'($urandom_range(1, 15));
        wdata = $urandom;
      end
      a_rdy = ($urandom % 8) != 0;
      dev_on = ($urandom % 4) != 0;
      inj_err = ($urandom % 16) == 0;
      inj_src = ($urandom % 16) == 0;
      inj_op = ($urandom % 16) == 0;
      force_dv = ($urandom % 32) == 0;
      rst_n = ($urandom % 64) != 0;
      cycle();
    end
    rst_n = 1; a_rdy = 1; dev_on = 1; force_dv = 0;
    inj_err = 0; inj_src = 0; inj_op = 0;
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
